serial_adder_ctrl: RTL



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/FA_2.sv | 13 +
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
// Optional subtract mode in serial_adder_ctrl is enabled by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    if (w <= 1) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/FA_2.sv
// 1-bit full-adder cell, time-shared by the serial adder sequencer.
module FA_2 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell processes W-bit operands LSB first,
// one bit per clock, behind valid/ready request and response ports.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one operand bit per cycle through the FA cell
// DONE  | result presented, waiting for out_ready
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  sa_state_t     state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  sum_sh;
  logic          carry;
  logic [CW-1:0] count;

  logic [W-1:0]  b_load;
  logic          c_load;
  logic          fa_s;
  logic          fa_cout;

  // Operand B and initial carry as loaded on accept (inverted B plus 1 for subtract).
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  FA_2 u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Sequencer FSM with operand/sum shift registers and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b_load;
            carry  <= c_load;
            sum_sh <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          // New sum bit enters at the MSB so the LSB lands at bit 0 after W shifts.
          sum_sh <= (sum_sh >> 1) | (W'(fa_s) << (W - 1));
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          // Counter stops at the last bit index rather than wrapping.
          if (count == LAST_BIT) begin
            state <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status outputs decode from the state register only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
    sum       = sum_sh;
    cout      = carry;
  end

endmodule
